// File: rtl/pe_link_fifo.sv
// pe_link_fifo: elastic ready/valid register FIFO linking one PE tile's east output to the next tile's west input
module pe_link_fifo #(
  parameter int LINK_WIDTH         = 130,
  parameter int NUM_BRAM_ADDR_BITS = 3,
  parameter int AFULL_MARGIN       = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ap_start,
  input  logic [LINK_WIDTH-1:0]       in_from_west,
  output logic                        out_to_west,
  output logic [LINK_WIDTH-1:0]       out_to_east,
  input  logic                        in_from_east,
  output logic [NUM_BRAM_ADDR_BITS:0] count,
  output logic                        almost_full
);
  localparam int AW = NUM_BRAM_ADDR_BITS;
  localparam int CW = AW + 1;
  localparam int DEPTH = 2 ** AW;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_TH = CW'(DEPTH - AFULL_MARGIN);
  // The valid bit is implied by occupancy, so only last+payload are stored.
  logic [LINK_WIDTH-2:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic ready_q, afull_q;
  logic head_vld, push, pop;
  assign head_vld    = (count_q != '0) & ap_start;
  assign out_to_east = head_vld ? {1'b1, mem_q[rd_ptr_q]} : '0;
  assign push        = in_from_west[LINK_WIDTH-1] & ready_q;
  assign pop         = head_vld & in_from_east;
  assign out_to_west = ready_q;
  assign count       = count_q;
  assign almost_full = afull_q;
  // Next occupancy; a simultaneous push and pop cancel out.
  always_comb count_d = count_q + CW'(push) - CW'(pop);
  // Storage write; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_from_west[LINK_WIDTH-2:0];
  end
  // Pointers, occupancy and registered flags derived from next-state occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q  <= count_d;
      ready_q  <= count_d != FULL;
      afull_q  <= count_d >= AFULL_TH;
    end
  end
endmodule

// File: tb/tb_pe_link_fifo.sv
// tb_pe_link_fifo: scoreboard bench for the PE link FIFO
module tb_pe_link_fifo;
  localparam int W = 130;
  logic clk = 1'b0;
  logic rst_n, ap, ein, rdy, af;
  logic [W-1:0] win, eout;
  logic [3:0] cnt;
  logic [W-1:0] q[$];
  int n_chk = 0, n_err = 0, n_pop = 0, k, p0;
  logic acc;

  pe_link_fifo dut (
    .clk(clk), .reset(rst_n), .ap_start(ap), .in_from_west(win), .out_to_west(rdy),
    .out_to_east(eout), .in_from_east(ein), .count(cnt), .almost_full(af)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic v, input logic l, input int p);
    return {v, l, 128'(unsigned'(p))};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are stable between posedge+1 and the next posedge, so the falling edge sees what the rising edge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (win[W-1] && rdy) q.push_back(win);
      if (eout[W-1] && ein) begin
        n_pop++;
        if (q.size() == 0) check_eq("pop_empty", eout, '0);
        else check_eq("order", eout, q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; ap = 1'b0; ein = 1'b0; win = mk(1'b1, 1'b0, 'h55);
    #2;
    check_eq("rst_out", eout, '0);
    check_eq("rst_rdy", W'(rdy), '0);
    check_eq("rst_cnt", W'(cnt), '0);
    check_eq("rst_af", W'(af), '0);
    tick();
    check_eq("rst_hold_rdy", W'(rdy), '0);
    win = '0;
    rst_n = 1'b1;
    tick();
    check_eq("rdy_release", W'(rdy), 1);
    // single word
    ap = 1'b1; ein = 1'b1; win = mk(1'b1, 1'b1, 'hABC);
    tick();
    win = '0;
    check_eq("single_head", eout, mk(1'b1, 1'b1, 'hABC));
    check_eq("single_cnt1", W'(cnt), 1);
    tick();
    check_eq("single_cnt0", W'(cnt), 0);
    check_eq("single_empty", eout, '0);
    // fill and backpressure
    p0 = n_pop;
    ein = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      win = mk(1'b1, i[0], i);
      tick();
      if (i == 5) check_eq("af_at5", W'(af), 0);
      if (i == 6) check_eq("af_at6", W'(af), 1);
      if (i == 8) check_eq("rdy_full", W'(rdy), 0);
    end
    win = '0;
    check_eq("fill_cnt", W'(cnt), 8);
    check_eq("fill_rdy", W'(rdy), 0);
    check_eq("fill_af", W'(af), 1);
    ein = 1'b1;
    k = 9;
    for (int c = 0; c < 40 && (k <= 10 || cnt != 0); c++) begin
      win = (k <= 10) ? mk(1'b1, k[0], k) : '0;
      acc = rdy;
      tick();
      if (acc && k <= 10) k++;
    end
    win = '0;
    check_eq("fill_drain_cnt", W'(cnt), 0);
    check_eq("fill_drain_q", W'(q.size()), 0);
    check_eq("fill_pops", W'(n_pop - p0), 10);
    // simultaneous push/pop at DEPTH-1 with pointer wrap
    p0 = n_pop;
    ein = 1'b0;
    for (int i = 0; i < 7; i++) begin
      win = mk(1'b1, 1'b0, 100 + i);
      tick();
    end
    check_eq("ss_pre_cnt", W'(cnt), 7);
    ein = 1'b1;
    for (int j = 0; j < 20; j++) begin
      win = mk(1'b1, j[0], 200 + j);
      tick();
      check_eq("ss_cnt", W'(cnt), 7);
    end
    win = '0;
    for (int c = 0; c < 20 && cnt != 0; c++) tick();
    check_eq("ss_drain_cnt", W'(cnt), 0);
    check_eq("ss_drain_q", W'(q.size()), 0);
    check_eq("ss_pops", W'(n_pop - p0), 27);
    // ap_start gating
    ap = 1'b0; ein = 1'b1;
    for (int i = 0; i < 3; i++) begin
      win = mk(1'b1, 1'b1, 300 + i);
      tick();
    end
    win = '0;
    check_eq("gate_hold", eout, '0);
    check_eq("gate_cnt", W'(cnt), 3);
    tick();
    check_eq("gate_hold2", W'(cnt), 3);
    ap = 1'b1;
    #1;
    check_eq("gate_rise", eout, mk(1'b1, 1'b1, 300));
    for (int i = 2; i >= 0; i--) begin
      tick();
      check_eq("gate_drain", W'(cnt), W'(i));
    end
    // mid-run reset
    ein = 1'b0;
    for (int i = 0; i < 5; i++) begin
      win = mk(1'b1, 1'b0, 400 + i);
      tick();
    end
    win = '0;
    check_eq("mr_cnt5", W'(cnt), 5);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check_eq("mr_out", eout, '0);
    check_eq("mr_cnt", W'(cnt), 0);
    check_eq("mr_rdy", W'(rdy), 0);
    tick();
    rst_n = 1'b1;
    ein = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("mr_no_valid", eout, '0);
    end
    check_eq("mr_final_cnt", W'(cnt), 0);
    check_eq("mr_rdy_back", W'(rdy), 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
